// File: rtl/centroid_moment_accumulator.sv
// Sums signed per-cycle moment contributions over a corner window and queues the
// completed {m10, m01} pair for the orientation stage through a small FIFO.
//
// state | meaning
// IDLE  | no window open; waiting for win_start
// ACC   | window open; accumulating samples until cnt reaches WIN_LEN
module centroid_moment_accumulator #(
    parameter int DATA_W     = 16,
    parameter int WIN_LEN    = 43,
    parameter int ACC_W      = 22,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              win_start,
    input  logic              win_en,
    input  logic [DATA_W-1:0] m10_part,
    input  logic [DATA_W-1:0] m01_part,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_m10,
    output logic [ACC_W-1:0]  out_m01,
    output logic              short_err,
    output logic              ovf,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W = $clog2(WIN_LEN + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ACC_W-1:0] acc_m10, acc_m01, acc_m10_nxt, acc_m01_nxt;
    logic [ACC_W-1:0] smp_m10, smp_m01, sum_m10, sum_m01;
    logic [ACC_W-1:0] push_m10, push_m01;
    logic             push;
    logic             short_nxt;

    logic [ACC_W-1:0] q_m10 [FIFO_DEPTH];
    logic [ACC_W-1:0] q_m01 [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             full, pop, wr_en, drop;

    assign smp_m10 = {{(ACC_W-DATA_W){m10_part[DATA_W-1]}}, m10_part};
    assign smp_m01 = {{(ACC_W-DATA_W){m01_part[DATA_W-1]}}, m01_part};
    assign sum_m10 = acc_m10 + smp_m10;
    assign sum_m01 = acc_m01 + smp_m01;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_m10   <= '0;
            acc_m01   <= '0;
            short_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc_m10   <= acc_m10_nxt;
            acc_m01   <= acc_m01_nxt;
            short_err <= short_nxt;
        end
    end

    // A start always wins, so a retrigger in ACC silently restarts the window.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_m10_nxt = acc_m10;
        acc_m01_nxt = acc_m01;
        push        = 1'b0;
        push_m10    = sum_m10;
        push_m01    = sum_m01;
        short_nxt   = 1'b0;
        if (ena) begin
            if (win_start) begin
                acc_m10_nxt = smp_m10;
                acc_m01_nxt = smp_m01;
                cnt_nxt     = CNT_W'(1);
                state_nxt   = ACC;
                if (WIN_LEN == 1) begin
                    push      = 1'b1;
                    push_m10  = smp_m10;
                    push_m01  = smp_m01;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end else if (state == ACC) begin
                if (win_en) begin
                    acc_m10_nxt = sum_m10;
                    acc_m01_nxt = sum_m01;
                    cnt_nxt     = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIN_LEN - 1)) begin
                        push      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt   = '0;
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (occ != '0);
    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    // When full, a same-edge pop frees the head slot, which wr_ptr already points at.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign out_m10   = q_m10[rd_ptr];
    assign out_m01   = q_m01[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_m10[i] <= '0;
                q_m01[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                q_m10[wr_ptr] <= push_m10;
                q_m01[wr_ptr] <= push_m01;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule
